// File: rtl/regfile_pkg.sv
// +----------------------------------------------------------------------------+
// | regfile_pkg : shared widths, bus types and the zero-register index          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

    localparam int c_REG_BUS_WIDTH  = 32;
    localparam int c_REG_ADDR_WIDTH = 5;
    localparam int c_PEND_WIDTH     = 2;
    localparam int c_ZERO_REG       = 0;

    typedef logic [c_REG_BUS_WIDTH-1:0]  RegBus;
    typedef logic [c_REG_ADDR_WIDTH-1:0] RegAddressBus;
    typedef logic [c_PEND_WIDTH-1:0]     PendBus;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// +----------------------------------------------------------------------------+
// | regfile_scoreboard : per-register in-flight write counters, issue back-     |
// | pressure and read-port busy. REGFILE_BYPASS_EN discounts a same-cycle write.|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = c_REG_ADDR_WIDTH,
    parameter int PEND_WIDTH = c_PEND_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] issue_address,
    output logic                  issue_ready,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic                  flush,
    input  logic                  read1,
    input  logic [ADDR_WIDTH-1:0] read1_address,
    input  logic                  read2,
    input  logic [ADDR_WIDTH-1:0] read2_address,
    output logic                  stall
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PEND_WIDTH-1:0] c_PEND_MAX = '1;

    logic [PEND_WIDTH-1:0] r_pend [c_DEPTH];
    logic                  w_issue_fire;
    logic                  w_busy1;
    logic                  w_busy2;

    assign issue_ready  = !((issue_address != '0) && (r_pend[issue_address] == c_PEND_MAX));
    assign w_issue_fire = issue && issue_ready;

    // Entry 0 is only ever written by reset, so x0 can never look busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = c_ZERO_REG + 1; i < c_DEPTH; i++) begin
                if (flush) begin
                    r_pend[i] <= '0;
                end else if (w_issue_fire && (issue_address == ADDR_WIDTH'(i))
                             && !(write && (write_address == ADDR_WIDTH'(i)))) begin
                    r_pend[i] <= r_pend[i] + 1'b1;
                end else if (write && (write_address == ADDR_WIDTH'(i))
                             && !(w_issue_fire && (issue_address == ADDR_WIDTH'(i)))
                             && (r_pend[i] != '0)) begin
                    r_pend[i] <= r_pend[i] - 1'b1;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // A write landing this cycle retires one outstanding count early.
    assign w_busy1 = (read1_address != '0) &&
                     (r_pend[read1_address] > PEND_WIDTH'(write && (write_address == read1_address)));
    assign w_busy2 = (read2_address != '0) &&
                     (r_pend[read2_address] > PEND_WIDTH'(write && (write_address == read2_address)));
`else
    assign w_busy1 = (read1_address != '0) && (r_pend[read1_address] != '0);
    assign w_busy2 = (read2_address != '0) && (r_pend[read2_address] != '0);
`endif

    assign stall = (read1 && w_busy1) || (read2 && w_busy2);

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// +----------------------------------------------------------------------------+
// | regfile : 2R/1W integer register file, x0 hardwired to zero, with in-flight |
// | write scoreboard. REGFILE_BYPASS_EN enables write-to-read forwarding.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = c_REG_BUS_WIDTH,
    parameter int ADDR_WIDTH = c_REG_ADDR_WIDTH,
    parameter int PEND_WIDTH = c_PEND_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read1,
    input  logic [ADDR_WIDTH-1:0] read1_address,
    output logic [DATA_WIDTH-1:0] read1_data,
    input  logic                  read2,
    input  logic [ADDR_WIDTH-1:0] read2_address,
    output logic [DATA_WIDTH-1:0] read2_data,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  issue,
    input  logic [ADDR_WIDTH-1:0] issue_address,
    output logic                  issue_ready,
    input  logic                  flush,
    output logic                  stall
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (write && (write_address != '0)) begin
            r_regs[write_address] <= write_data;
        end
    end

    always_comb begin
        read1_data = '0;
        read2_data = '0;
        if (read1 && (read1_address != '0)) begin
            read1_data = r_regs[read1_address];
        end
        if (read2 && (read2_address != '0)) begin
            read2_data = r_regs[read2_address];
        end
`ifdef REGFILE_BYPASS_EN
        if (read1 && write && (write_address != '0) && (read1_address == write_address)) begin
            read1_data = write_data;
        end
        if (read2 && write && (write_address != '0) && (read2_address == write_address)) begin
            read2_data = write_data;
        end
`endif
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PEND_WIDTH (PEND_WIDTH)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .issue         (issue),
        .issue_address (issue_address),
        .issue_ready   (issue_ready),
        .write         (write),
        .write_address (write_address),
        .flush         (flush),
        .read1         (read1),
        .read1_address (read1_address),
        .read2         (read2),
        .read2_address (read2_address),
        .stall         (stall)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// +----------------------------------------------------------------------------+
// | tb_regfile : directed self-checking bench for regfile                       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile;

    logic        clk;
    logic        reset;
    logic        read1;
    logic [4:0]  read1_address;
    logic [31:0] read1_data;
    logic        read2;
    logic [4:0]  read2_address;
    logic [31:0] read2_data;
    logic        write;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        issue;
    logic [4:0]  issue_address;
    logic        issue_ready;
    logic        flush;
    logic        stall;

    int total;
    int bad;

    regfile #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .PEND_WIDTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read1         (read1),
        .read1_address (read1_address),
        .read1_data    (read1_data),
        .read2         (read2),
        .read2_address (read2_address),
        .read2_data    (read2_data),
        .write         (write),
        .write_address (write_address),
        .write_data    (write_data),
        .issue         (issue),
        .issue_address (issue_address),
        .issue_ready   (issue_ready),
        .flush         (flush),
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then return at the following falling edge with controls idle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        issue = 1'b0;
        flush = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        read1 = 1'b0; read1_address = '0;
        read2 = 1'b0; read2_address = '0;
        write = 1'b0; write_address = '0; write_data = '0;
        issue = 1'b0; issue_address = '0;
        flush = 1'b0;

        // Reset state
        @(negedge clk);
        read1 = 1'b1; read1_address = 5'd3;
        read2 = 1'b1; read2_address = 5'd3;
        settle();
        check("rst_read1", read1_data, 32'h0);
        check("rst_read2", read2_data, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_ready", {31'h0, issue_ready}, 32'h1);
        read1 = 1'b0; read2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Write/read and x0
        write = 1'b1; write_address = 5'd3; write_data = 32'hDEADBEEF;
        step();
        write = 1'b1; write_address = 5'd0; write_data = 32'hFFFFFFFF;
        step();
        read1 = 1'b1; read1_address = 5'd3;
        read2 = 1'b1; read2_address = 5'd3;
        settle();
        check("x3_read1", read1_data, 32'hDEADBEEF);
        check("x3_read2", read2_data, 32'hDEADBEEF);
        read1_address = 5'd0;
        settle();
        check("x0_read1", read1_data, 32'h0);
        read1 = 1'b0; read1_address = 5'd3;
        settle();
        check("read1_off", read1_data, 32'h0);
        read2 = 1'b0;

        // Scoreboard basic: issue x7, consume, write back
        issue = 1'b1; issue_address = 5'd7;
        settle();
        check("x7_ready", {31'h0, issue_ready}, 32'h1);
        step();
        read2 = 1'b1; read2_address = 5'd7;
        settle();
        check("x7_stall", {31'h0, stall}, 32'h1);
        write = 1'b1; write_address = 5'd7; write_data = 32'h55;
        settle();
`ifdef REGFILE_BYPASS_EN
        check("x7_wr_stall", {31'h0, stall}, 32'h0);
        check("x7_wr_data", read2_data, 32'h55);
`else
        check("x7_wr_stall", {31'h0, stall}, 32'h1);
        check("x7_wr_data", read2_data, 32'h0);
`endif
        step();
        settle();
        check("x7_after_stall", {31'h0, stall}, 32'h0);
        check("x7_after_data", read2_data, 32'h55);
        read2 = 1'b0;

        // Saturation on x9
        for (int k = 0; k < 3; k++) begin
            issue = 1'b1; issue_address = 5'd9;
            settle();
            check("x9_ready_pre", {31'h0, issue_ready}, 32'h1);
            step();
        end
        issue = 1'b1; issue_address = 5'd9;
        settle();
        check("x9_ready_full", {31'h0, issue_ready}, 32'h0);
        step();
        issue_address = 5'd9;
        settle();
        check("x9_ready_held", {31'h0, issue_ready}, 32'h0);
        issue_address = 5'd0;
        settle();
        check("x0_ready", {31'h0, issue_ready}, 32'h1);
        read1 = 1'b1; read1_address = 5'd9;
        write = 1'b1; write_address = 5'd9; write_data = 32'h9;
        step();
        settle();
        check("x9_stall_2left", {31'h0, stall}, 32'h1);
        write = 1'b1; write_address = 5'd9; write_data = 32'h9;
        step();
        write = 1'b1; write_address = 5'd9; write_data = 32'h9;
        step();
        settle();
        check("x9_stall_done", {31'h0, stall}, 32'h0);
        // Unissued write must saturate at zero rather than wrap
        write = 1'b1; write_address = 5'd9; write_data = 32'h99;
        step();
        issue = 1'b1; issue_address = 5'd9;
        step();
        settle();
        check("x9_sat_zero", {31'h0, stall}, 32'h1);
        write = 1'b1; write_address = 5'd9; write_data = 32'h99;
        step();
        settle();
        check("x9_clear", {31'h0, stall}, 32'h0);
        read1 = 1'b0;

        // Simultaneous issue and write on x4 with pend=1
        issue = 1'b1; issue_address = 5'd4;
        step();
        issue = 1'b1; issue_address = 5'd4;
        write = 1'b1; write_address = 5'd4; write_data = 32'h44;
        step();
        read1 = 1'b1; read1_address = 5'd4;
        settle();
        check("x4_simul_stall", {31'h0, stall}, 32'h1);
        check("x4_simul_data", read1_data, 32'h44);
        write = 1'b1; write_address = 5'd4; write_data = 32'h45;
        step();
        settle();
        check("x4_clear", {31'h0, stall}, 32'h0);
        read1 = 1'b0;

        // Flush with same-cycle write and issue
        issue = 1'b1; issue_address = 5'd6;
        step();
        issue = 1'b1; issue_address = 5'd6;
        step();
        issue = 1'b1; issue_address = 5'd8;
        step();
        read1 = 1'b1; read1_address = 5'd6;
        read2 = 1'b1; read2_address = 5'd8;
        settle();
        check("pre_flush_stall", {31'h0, stall}, 32'h1);
        flush = 1'b1;
        write = 1'b1; write_address = 5'd6; write_data = 32'h77;
        issue = 1'b1; issue_address = 5'd8;
        step();
        settle();
        check("flush_stall", {31'h0, stall}, 32'h0);
        check("flush_x6_data", read1_data, 32'h77);
        read1 = 1'b0; read2 = 1'b0;

        // Reset mid-operation, observed before any clock edge
        write = 1'b1; write_address = 5'd5; write_data = 32'h1234;
        step();
        issue = 1'b1; issue_address = 5'd10;
        step();
        read1 = 1'b1; read1_address = 5'd5;
        read2 = 1'b1; read2_address = 5'd10;
        settle();
        check("x5_before_rst", read1_data, 32'h1234);
        check("x10_before_rst", {31'h0, stall}, 32'h1);
        issue_address = 5'd10;
        reset = 1'b0;
        settle();
        check("midrst_read1", read1_data, 32'h0);
        check("midrst_stall", {31'h0, stall}, 32'h0);
        check("midrst_ready", {31'h0, issue_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        settle();
        check("post_rst_x5", read1_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
